// File: rtl/idct_stage3_pkg.sv
// rtl/idct_stage3_pkg.sv - shared DCT widths, constant shift-add terms and saturation helper
package dct_pkg;

    localparam int W_INT = 10;
    localparam int W_Y01 = 11;
    localparam int W_Q   = 25;
    localparam int W_YQ  = 26;
    localparam int FRAC  = 15;
    localparam int W_RW  = 29;

    typedef enum logic {K0, K1} kconst_e;

    // Term i contributes +/- (x >>> SH[i]) when EN[i] is set; NEG[i] selects subtraction.
    localparam logic [6:0][3:0] K0_SH  = {4'd0, 4'd14, 4'd12, 4'd9, 4'd7, 4'd5, 4'd1};
    localparam logic [6:0]      K0_EN  = 7'b0111111;
    localparam logic [6:0]      K0_NEG = 7'b0100000;
    localparam logic [6:0][3:0] K1_SH  = {4'd15, 4'd13, 4'd9, 4'd7, 4'd4, 4'd2, 4'd0};
    localparam logic [6:0]      K1_EN  = 7'b1111111;
    localparam logic [6:0]      K1_NEG = 7'b0101000;

    function automatic logic signed [W_RW-1:0] sat_clip(input logic signed [W_RW-1:0] x,
                                                        input int w);
        longint m;
        logic signed [W_RW-1:0] hi, lo;
        m  = longint'(1) << (w - 1);
        hi = W_RW'(m - 1);
        lo = W_RW'(-m);
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        return x;
    endfunction

endpackage

// File: rtl/idct_stage3_if.sv
// rtl/idct_stage3_if.sv - vector handshake bundle between a source/sink and idct_stage3
interface idct_stage3_if;
    import dct_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic signed [W_Y01-1:0] y0, y1;
    logic signed [W_YQ-1:0]  y2, y3, y4, y5, y6, y7;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [W_INT-1:0] r0, r1, r2, r3;
    logic signed [W_Q-1:0]   r4, r5, r6, r7;

    modport slave (
        input  in_valid, y0, y1, y2, y3, y4, y5, y6, y7, out_ready,
        output in_ready, out_valid, r0, r1, r2, r3, r4, r5, r6, r7
    );

    modport master (
        output in_valid, y0, y1, y2, y3, y4, y5, y6, y7, out_ready,
        input  in_ready, out_valid, r0, r1, r2, r3, r4, r5, r6, r7
    );

endinterface

// File: rtl/idct_stage3_cmul.sv
// rtl/idct_stage3_cmul.sv - multiply by rotation constant k0 or k1 using floor shift-add terms
module idct_cmul
    import dct_pkg::*;
#(
    parameter kconst_e K  = K0,
    parameter int      RW = W_RW
) (
    input  logic signed [RW-1:0] x_i,
    output logic signed [RW-1:0] p_o
);

    localparam logic [6:0][3:0] SH  = (K == K0) ? K0_SH  : K1_SH;
    localparam logic [6:0]      EN  = (K == K0) ? K0_EN  : K1_EN;
    localparam logic [6:0]      NEG = (K == K0) ? K0_NEG : K1_NEG;

    logic signed [RW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < 7; i++) begin
            if (EN[i]) begin
                if (NEG[i])
                    acc = acc - (x_i >>> SH[i]);
                else
                    acc = acc + (x_i >>> SH[i]);
            end
        end
        p_o = acc;
    end

endmodule

// File: rtl/idct_stage3.sv
// rtl/idct_stage3.sv - inverse DCT stage-3 butterfly/rotation, 2-stage valid/ready pipeline
module idct_stage3 #(
    parameter int FRAC = dct_pkg::FRAC,
    parameter int RW   = dct_pkg::W_RW
) (
    input  logic         clk,
    input  logic         reset,
    idct_stage3_if.slave bus,
    input  logic         sat_clr,
    output logic         sat
);
    import dct_pkg::*;

    localparam logic signed [RW-1:0] RND = RW'(1 << (FRAC - 1));

    logic                 en_a, en_b, load_b, any_sat, sat_d;
    logic                 va_q, vb_q, sat_q;
    logic signed [RW-1:0] y0x, y1x, y2x, y3x, y4x, y5x, y6x, y7x;
    logic signed [RW-1:0] p02_d, p13_d, p12_d, p03_d;
    logic signed [RW-1:0] s0_q, s1_q, s4_q, s5_q, s6_q, s7_q;
    logic signed [RW-1:0] p02_q, p13_q, p12_q, p03_q;
    logic signed [RW-1:0] pre [8];
    logic signed [RW-1:0] clp [8];
    logic signed [W_INT-1:0] r_lo_q [4];
    logic signed [W_Q-1:0]   r_hi_q [4];

    assign y0x = RW'(bus.y0);
    assign y1x = RW'(bus.y1);
    assign y2x = RW'(bus.y2);
    assign y3x = RW'(bus.y3);
    assign y4x = RW'(bus.y4);
    assign y5x = RW'(bus.y5);
    assign y6x = RW'(bus.y6);
    assign y7x = RW'(bus.y7);

    idct_cmul #(.K(K0), .RW(RW)) u_p02 (.x_i(y2x), .p_o(p02_d));
    idct_cmul #(.K(K1), .RW(RW)) u_p13 (.x_i(y3x), .p_o(p13_d));
    idct_cmul #(.K(K1), .RW(RW)) u_p12 (.x_i(y2x), .p_o(p12_d));
    idct_cmul #(.K(K0), .RW(RW)) u_p03 (.x_i(y3x), .p_o(p03_d));

    // A stage may load whenever the stage after it is empty or draining this cycle.
    assign en_b   = !vb_q || bus.out_ready;
    assign en_a   = !va_q || en_b;
    assign load_b = en_b && va_q;

    assign bus.in_ready  = en_a;
    assign bus.out_valid = vb_q;

    always_comb begin
        pre[0] = s0_q >>> 1;
        pre[1] = s1_q >>> 1;
        pre[2] = (((p02_q - p13_q) >>> 1) + RND) >>> FRAC;
        pre[3] = (((p12_q + p03_q) >>> 1) + RND) >>> FRAC;
        pre[4] = s4_q >>> 1;
        pre[5] = s5_q >>> 1;
        pre[6] = s6_q >>> 1;
        pre[7] = s7_q >>> 1;
        any_sat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            clp[i]  = sat_clip(pre[i], (i < 4) ? W_INT : W_Q);
            any_sat = any_sat || (clp[i] != pre[i]);
        end
    end

    // A fresh saturation outranks a clear arriving on the same edge.
    assign sat_d = (sat_q && !sat_clr) || (load_b && any_sat);
    assign sat   = sat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            va_q  <= 1'b0;
            vb_q  <= 1'b0;
            sat_q <= 1'b0;
            s0_q  <= '0;
            s1_q  <= '0;
            s4_q  <= '0;
            s5_q  <= '0;
            s6_q  <= '0;
            s7_q  <= '0;
            p02_q <= '0;
            p13_q <= '0;
            p12_q <= '0;
            p03_q <= '0;
            for (int i = 0; i < 4; i++) begin
                r_lo_q[i] <= '0;
                r_hi_q[i] <= '0;
            end
        end else begin
            sat_q <= sat_d;
            if (en_a)
                va_q <= bus.in_valid;
            if (en_a && bus.in_valid) begin
                s0_q  <= y0x + y1x;
                s1_q  <= y0x - y1x;
                s4_q  <= y4x + y6x;
                s6_q  <= y4x - y6x;
                s7_q  <= y5x + y7x;
                s5_q  <= y7x - y5x;
                p02_q <= p02_d;
                p13_q <= p13_d;
                p12_q <= p12_d;
                p03_q <= p03_d;
            end
            if (en_b)
                vb_q <= va_q;
            if (load_b) begin
                for (int i = 0; i < 4; i++) begin
                    r_lo_q[i] <= clp[i][W_INT-1:0];
                    r_hi_q[i] <= clp[i+4][W_Q-1:0];
                end
            end
        end
    end

    assign bus.r0 = r_lo_q[0];
    assign bus.r1 = r_lo_q[1];
    assign bus.r2 = r_lo_q[2];
    assign bus.r3 = r_lo_q[3];
    assign bus.r4 = r_hi_q[0];
    assign bus.r5 = r_hi_q[1];
    assign bus.r6 = r_hi_q[2];
    assign bus.r7 = r_hi_q[3];

endmodule

// File: tb/tb_idct_stage3.sv
// tb/tb_idct_stage3.sv - scoreboard bench for idct_stage3
module tb_idct_stage3;
    import dct_pkg::*;

    logic clk;
    logic reset;
    logic sat_clr;
    logic sat;
    int   n_vec;
    int   n_err;
    longint exp_q[$];

    idct_stage3_if bus ();

    idct_stage3 dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .sat_clr(sat_clr),
        .sat    (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint k0m(input longint x);
        return (x >>> 1) + (x >>> 5) + (x >>> 7) + (x >>> 9) + (x >>> 12) - (x >>> 14);
    endfunction

    function automatic longint k1m(input longint x);
        return x + (x >>> 2) + (x >>> 4) - (x >>> 7) + (x >>> 9) - (x >>> 13) + (x >>> 15);
    endfunction

    function automatic longint clip(input longint x, input int w);
        longint m;
        m = longint'(1) << (w - 1);
        if (x > m - 1) return m - 1;
        if (x < -m) return -m;
        return x;
    endfunction

    function automatic longint rnd(input int w);
        longint v;
        v = longint'({$urandom, $urandom});
        v = (v <<< (64 - w)) >>> (64 - w);
        return v;
    endfunction

    task automatic push_exp(input longint a0, a1, a2, a3, a4, a5, a6, a7);
        exp_q.push_back(clip((a0 + a1) >>> 1, 10));
        exp_q.push_back(clip((a0 - a1) >>> 1, 10));
        exp_q.push_back(clip((((k0m(a2) - k1m(a3)) >>> 1) + 16384) >>> 15, 10));
        exp_q.push_back(clip((((k1m(a2) + k0m(a3)) >>> 1) + 16384) >>> 15, 10));
        exp_q.push_back(clip((a4 + a6) >>> 1, 25));
        exp_q.push_back(clip((a7 - a5) >>> 1, 25));
        exp_q.push_back(clip((a4 - a6) >>> 1, 25));
        exp_q.push_back(clip((a5 + a7) >>> 1, 25));
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the vector.
    task automatic send(input longint a0, a1, a2, a3, a4, a5, a6, a7);
        bit ok;
        bus.y0 = 11'(a0);
        bus.y1 = 11'(a1);
        bus.y2 = 26'(a2);
        bus.y3 = 26'(a3);
        bus.y4 = 26'(a4);
        bus.y5 = 26'(a5);
        bus.y6 = 26'(a6);
        bus.y7 = 26'(a7);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
        end
        if (!ok)
            check("send_timeout", 0, 1);
        else
            push_exp(a0, a1, a2, a3, a4, a5, a6, a7);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rnd();
        send(rnd(11), rnd(11), rnd(26), rnd(26), rnd(26), rnd(26), rnd(26), rnd(26));
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        sat_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() < 8) begin
                check("unexpected_out", 1, 0);
            end else begin
                check("r0", bus.r0, exp_q.pop_front());
                check("r1", bus.r1, exp_q.pop_front());
                check("r2", bus.r2, exp_q.pop_front());
                check("r3", bus.r3, exp_q.pop_front());
                check("r4", bus.r4, exp_q.pop_front());
                check("r5", bus.r5, exp_q.pop_front());
                check("r6", bus.r6, exp_q.pop_front());
                check("r7", bus.r7, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        time    t0;
        longint h0, h4;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        sat_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;

        // reset held with random activity on the inputs
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            bus.y0 = 11'(rnd(11));
            bus.y2 = 26'(rnd(26));
            bus.y5 = 26'(rnd(26));
            sat_clr = 1'($urandom);
        end
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_sat", sat, 0);
        check("rst_r0", bus.r0, 0);
        check("rst_r2", bus.r2, 0);
        check("rst_r4", bus.r4, 0);
        check("rst_r7", bus.r7, 0);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        sat_clr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // butterflies and two-cycle latency
        send(10, 4, 0, 0, 98304, 65536, 32768, 131072);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", bus.out_valid, 0);
        @(negedge clk);
        check("lat_cycle2", bus.out_valid, 1);
        drain();

        // rotation, both orientations
        send(0, 0, 3276800, 0, 0, 0, 0, 0);
        send(0, 0, 0, 3276800, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        drain();

        // full throughput with out_ready high
        t0 = $time;
        repeat (8) send_rnd();
        check("throughput_cycles", ($time - t0) / 10, 8);
        bus.in_valid = 1'b0;
        drain();

        // sticky saturation, clear, and set-wins-over-clear
        pulse_clr();
        check("sat_cleared0", sat, 0);
        send(0, 0, 33554431, -33554432, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        drain();
        check("sat_set", sat, 1);
        pulse_clr();
        check("sat_cleared1", sat, 0);
        send(0, 0, 33554431, -33554432, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        check("sat_before_load", sat, 0);
        pulse_clr();
        check("sat_set_wins", sat, 1);
        drain();
        pulse_clr();

        // backpressure: 6 vectors into a 2-deep pipe stalled for 5 cycles
        bus.out_ready = 1'b0;
        fork
            begin
                repeat (6) send_rnd();
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready", bus.in_ready, 0);
                check("bp_out_valid", bus.out_valid, 1);
                h0 = bus.r0;
                h4 = bus.r4;
                repeat (2) begin
                    @(negedge clk);
                    check("bp_hold_r0", bus.r0, h0);
                    check("bp_hold_r4", bus.r4, h4);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // reset while two vectors are in flight
        bus.out_ready = 1'b0;
        send_rnd();
        send_rnd();
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_rnd();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_lat1", bus.out_valid, 0);
        @(negedge clk);
        check("post_rst_lat2", bus.out_valid, 1);
        drain();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
